// File: rtl/npxl_receiver_if.sv
// rtl/npxl_receiver_if.sv - decoded pixel/frame output bundle of the NeoPixel receiver
//
// Signals (driven by the receiver through modport master):
//   o_pixel      [23:0]     last completed GRB word, held until the next one
//   o_index      [ADDR-1:0] index of o_pixel within the current frame
//   o_valid                 one-cycle strobe: o_pixel / o_index are new
//   o_frame_done            one-cycle strobe on latch gap detection
//   o_count      [ADDR-1:0] complete words in the finished frame, held
//   o_err                   one-cycle strobe on glitch, fault or partial word
interface npxl_receiver_if #(
    parameter int ADDR = 8
);
    logic [23:0]     o_pixel;
    logic [ADDR-1:0] o_index;
    logic            o_valid;
    logic            o_frame_done;
    logic [ADDR-1:0] o_count;
    logic            o_err;

    modport master (
        output o_pixel, o_index, o_valid, o_frame_done, o_count, o_err
    );

    modport slave (
        input o_pixel, o_index, o_valid, o_frame_done, o_count, o_err
    );
endinterface

// File: rtl/npxl_receiver.sv
// rtl/npxl_receiver.sv - WS2812 single-wire bit-stream receiver and frame decoder
//
// Ports:
//   i_clk        system clock (48 MHz)
//   i_rst        synchronous active-high reset
//   i_npxl_data  asynchronous NeoPixel serial line
//   pix          npxl_receiver_if.master: pixel word, index, strobes, frame count
//
// The line is synchronized (s1, s2) and delayed once more (s3) for edge
// detection. High-pulse widths are counted in cycles of s2 being high and
// decoded against THRESH; 24 bits form one GRB word, MSB first. A low period
// of RESET_CYC cycles latches the frame.
module npxl_receiver #(
    parameter int ADDR      = 8,
    parameter int THRESH    = 29,
    parameter int MIN_HIGH  = 8,
    parameter int MAX_HIGH  = 90,
    parameter int RESET_CYC = 2400
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_npxl_data,
    npxl_receiver_if.master    pix
);

    localparam int CW = $clog2(RESET_CYC + 1);

    localparam logic [CW-1:0] THRESH_C   = CW'(THRESH);
    localparam logic [CW-1:0] MIN_C      = CW'(MIN_HIGH);
    localparam logic [CW-1:0] MAX_C      = CW'(MAX_HIGH);
    localparam logic [CW-1:0] RESET_LIM  = CW'(RESET_CYC);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_TWO    = CW'(2);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    logic s1, s2, s3;
    logic rise;

    state_t          state, state_n;
    logic [CW-1:0]   hi_cnt, hi_n;
    logic [CW-1:0]   lo_cnt, lo_n;
    logic [23:0]     shreg, sh_n;
    logic [4:0]      bit_cnt, bit_n;
    logic [ADDR-1:0] word_cnt, word_n;

    logic [23:0]     pixel_n;
    logic [ADDR-1:0] index_n;
    logic [ADDR-1:0] count_n;
    logic            valid_n, done_n, err_n;
    logic            bit_val;

    assign rise    = s2 & ~s3;
    assign bit_val = (hi_cnt >= THRESH_C);

    always_comb begin
        state_n = state;
        hi_n    = hi_cnt;
        lo_n    = lo_cnt;
        sh_n    = shreg;
        bit_n   = bit_cnt;
        word_n  = word_cnt;
        pixel_n = pix.o_pixel;
        index_n = pix.o_index;
        count_n = pix.o_count;
        valid_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            ST_SYNC: begin
                if (s2) begin
                    lo_n = '0;
                end else if (lo_cnt == RESET_LIM - CNT_ONE) begin
                    lo_n    = RESET_LIM;
                    state_n = ST_IDLE;
                end else begin
                    lo_n = lo_cnt + CNT_ONE;
                end
            end

            ST_IDLE: begin
                // The rise cycle itself counts as a high cycle. s2 high
                // without a rise only happens after a latch that coincided
                // with a rise, in which case the line was already high for
                // one cycle.
                if (s2) begin
                    hi_n    = rise ? CNT_ONE : CNT_TWO;
                    state_n = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (s2) begin
                    if (hi_cnt >= MAX_C) begin
                        // Stuck-high line: abandon the word and the frame.
                        err_n   = 1'b1;
                        hi_n    = '0;
                        lo_n    = '0;
                        sh_n    = '0;
                        bit_n   = '0;
                        word_n  = '0;
                        state_n = ST_SYNC;
                    end else begin
                        hi_n = hi_cnt + CNT_ONE;
                    end
                end else begin
                    // First low s2 cycle in HIGH is the fall; hi_cnt is the width.
                    lo_n    = '0;
                    state_n = ST_LOW;
                    if (hi_cnt < MIN_C) begin
                        err_n = 1'b1;
                    end else begin
                        sh_n = {shreg[22:0], bit_val};
                        if (bit_cnt == 5'd23) begin
                            pixel_n = {shreg[22:0], bit_val};
                            index_n = word_cnt;
                            valid_n = 1'b1;
                            word_n  = word_cnt + 1'b1;
                            bit_n   = '0;
                        end else begin
                            bit_n = bit_cnt + 5'd1;
                        end
                    end
                end
            end

            ST_LOW: begin
                // Latch takes priority over a rise arriving on the same cycle.
                if (lo_cnt == RESET_LIM - CNT_ONE) begin
                    lo_n    = RESET_LIM;
                    done_n  = 1'b1;
                    err_n   = (bit_cnt != 5'd0);
                    count_n = word_cnt;
                    word_n  = '0;
                    bit_n   = '0;
                    sh_n    = '0;
                    index_n = '0;
                    state_n = ST_IDLE;
                end else if (s2) begin
                    hi_n    = CNT_ONE;
                    state_n = ST_HIGH;
                end else begin
                    lo_n = lo_cnt + CNT_ONE;
                end
            end

            default: begin
                state_n = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1               <= 1'b0;
            s2               <= 1'b0;
            s3               <= 1'b0;
            state            <= ST_SYNC;
            hi_cnt           <= '0;
            lo_cnt           <= '0;
            shreg            <= '0;
            bit_cnt          <= '0;
            word_cnt         <= '0;
            pix.o_pixel      <= '0;
            pix.o_index      <= '0;
            pix.o_count      <= '0;
            pix.o_valid      <= 1'b0;
            pix.o_frame_done <= 1'b0;
            pix.o_err        <= 1'b0;
        end else begin
            s1               <= i_npxl_data;
            s2               <= s1;
            s3               <= s2;
            state            <= state_n;
            hi_cnt           <= hi_n;
            lo_cnt           <= lo_n;
            shreg            <= sh_n;
            bit_cnt          <= bit_n;
            word_cnt         <= word_n;
            pix.o_pixel      <= pixel_n;
            pix.o_index      <= index_n;
            pix.o_count      <= count_n;
            pix.o_valid      <= valid_n;
            pix.o_frame_done <= done_n;
            pix.o_err        <= err_n;
        end
    end

endmodule

// File: tb/tb_npxl_receiver.sv
// tb/tb_npxl_receiver.sv - scoreboard testbench for npxl_receiver
module tb_npxl_receiver;

    localparam int RC = 2400;

    logic clk = 1'b0;
    logic rst;
    logic line;

    always #10 clk = ~clk;

    npxl_receiver_if #(.ADDR(8)) bus ();

    npxl_receiver #(
        .ADDR(8), .THRESH(29), .MIN_HIGH(8), .MAX_HIGH(90), .RESET_CYC(RC)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_npxl_data (line),
        .pix         (bus)
    );

    // kind: 0 = o_valid, 1 = o_frame_done, 2 = o_err alone
    typedef struct {
        int          kind;
        logic [23:0] pixel;
        logic [7:0]  index;
        logic [7:0]  count;
        logic        err;
        int          lat;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  last_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [23:0] pixel, input logic [7:0] index,
                        input logic [7:0] count, input logic err, input int lat);
        ev_t e;
        e.kind = kind; e.pixel = pixel; e.index = index;
        e.count = count; e.err = err; e.lat = lat;
        q.push_back(e);
    endtask

    // Monitor: pops one expected event per observed strobe.
    always @(negedge clk) begin
        if (bus.o_valid || bus.o_frame_done || bus.o_err) begin
            int  k;
            ev_t e;
            k = bus.o_valid ? 0 : (bus.o_frame_done ? 1 : 2);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", k, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", k, e.kind);
                if (e.kind == 0 && k == 0) begin
                    chk("valid_pixel", bus.o_pixel, e.pixel);
                    chk("valid_index", bus.o_index, e.index);
                    chk("valid_no_err", bus.o_err, 0);
                end
                if (e.kind == 1 && k == 1) begin
                    chk("frame_count", bus.o_count, e.count);
                    chk("frame_err", bus.o_err, e.err);
                end
                if (e.lat != 0)
                    chk("latency", cyc - last_fall, e.lat);
            end
        end
    end

    task automatic pulse(input int hi, input int lo);
        line = 1'b1;
        repeat (hi) @(negedge clk);
        line = 1'b0;
        last_fall = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(38, 22);
        else   pulse(19, 41);
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [23:0] w, input logic [7:0] idx);
        push(0, w, idx, 8'h0, 1'b0, 3);
        send_bits(w, 24);
    endtask

    task automatic gap(input int n);
        line = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_latch(input logic [7:0] cnt, input logic err);
        push(1, 24'h0, 8'h0, cnt, err, RC + 3);
    endtask

    initial begin
        rst  = 1'b1;
        line = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pixel", bus.o_pixel, 0);
        chk("rst_index", bus.o_index, 0);
        chk("rst_count", bus.o_count, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_done",  bus.o_frame_done, 0);
        chk("rst_err",   bus.o_err, 0);
        gap(RC + 10);

        // Single word and its frame latch
        send_word(24'hA5F00F, 8'd0);
        expect_latch(8'd1, 1'b0);
        gap(2500);

        // Three-word frame; next frame restarts at index 0
        send_word(24'h000001, 8'd0);
        send_word(24'hFFFFFF, 8'd1);
        send_word(24'h123456, 8'd2);
        expect_latch(8'd3, 1'b0);
        gap(2500);

        // Threshold boundary and glitch: 0 (28), 1 (29), glitch (7), 22 bits
        push(2, 24'h0, 8'h0, 8'h0, 1'b1, 3);
        push(0, 24'h4F0F0F, 8'd0, 8'h0, 1'b0, 3);
        pulse(28, 32);
        pulse(29, 31);
        pulse(7, 40);
        send_bits(24'h0F0F0F, 22);
        expect_latch(8'd1, 1'b0);
        gap(2500);

        // Stuck-high fault mid-word, resync, then a clean word
        push(2, 24'h0, 8'h0, 8'h0, 1'b1, 0);
        send_bits(24'h000155, 10);
        line = 1'b1;
        repeat (91) @(negedge clk);
        gap(2500);
        send_word(24'hC3C3C3, 8'd0);
        expect_latch(8'd1, 1'b0);
        gap(2500);

        // One word plus a partial word at latch
        send_word(24'h5A5A5A, 8'd0);
        send_bits(24'h0002AA, 10);
        expect_latch(8'd1, 1'b1);
        gap(2500);

        // Reset after 12 bits discards everything
        send_bits(24'h000ABC, 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pixel", bus.o_pixel, 0);
        chk("midrst_count", bus.o_count, 0);
        gap(2500);
        send_word(24'h9E3779, 8'd0);
        expect_latch(8'd1, 1'b0);
        gap(2500);

        for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npxl_receiver.md
# npxl_receiver

Single-wire NeoPixel (WS2812) bit-stream receiver: the receive-side counterpart of the NeoPixel transmit path. It samples a serial NeoPixel line at 48 MHz and decodes high-pulse widths into bits. It assembles 24-bit GRB pixel words, MSB first, and detects the reset/latch gap that ends a frame. It serves as a loopback checker for the LED transmit chain and as a front end for cascaded boards that take pixel data from an upstream controller.

## Interface
Parameters:
- ADDR, 8: width of the pixel index and pixel count outputs.
- THRESH, 29: high-pulse width in cycles; width ≥ THRESH decodes as 1, below decodes as 0 (T0H ≈ 19, T1H ≈ 38 cycles at 48 MHz).
- MIN_HIGH, 8: high pulses shorter than this are glitches.
- MAX_HIGH, 90: high pulses longer than this are line faults.
- RESET_CYC, 2400: low time that constitutes a latch (50 µs at 48 MHz).

Ports:
- i_clk  in  1  system clock, 48 MHz.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_npxl_data  in  1  asynchronous NeoPixel serial line.
- o_pixel  out  24  last completed GRB word; holds until the next word.
- o_index  out  ADDR  index of o_pixel within the current frame, starting at 0.
- o_valid  out  1  one-cycle strobe: o_pixel and o_index are new.
- o_frame_done  out  1  one-cycle strobe on latch detection.
- o_count  out  ADDR  number of complete words in the finished frame; valid with o_frame_done and held afterwards.
- o_err  out  1  one-cycle strobe on a glitch, a fault, or a partial word at latch.

## Operation
- i_npxl_data passes through a 2-flop synchronizer (s1, s2) and a third delay flop (s3). Rise = s2 & ~s3; fall = ~s2 & s3.
- The high counter and low counter are each wide enough to hold RESET_CYC and saturate there.
- FSM states:
  - SYNC: entered on reset. Waits for the line to stay low for RESET_CYC consecutive cycles, then moves to IDLE. No o_frame_done is issued on this exit.
  - IDLE: line low, between bits. On rise, clear the high counter and go to HIGH.
  - HIGH: count the cycles the line is high.
    - High count exceeds MAX_HIGH: pulse o_err, discard the partial word and the frame state, go to SYNC.
    - Fall with width < MIN_HIGH: pulse o_err, drop the bit, go to LOW.
    - Fall otherwise: shift in bit (width ≥ THRESH), go to LOW.
  - LOW: count the cycles the line is low.
    - Rise: go to HIGH.
    - Low count reaches RESET_CYC: latch. Pulse o_frame_done, load o_count with the word counter, then clear the word counter, bit counter and index. Go to IDLE.
- Word assembly: shift register, first bit into bit 23. On the 24th bit:
  - Load o_pixel.
  - Drive o_index = word counter.
  - Pulse o_valid.
  - Increment the word counter (wraps modulo 2^ADDR).
  - Clear the bit counter.
- Latch with bit counter ≠ 0: discard the partial bits and pulse o_err in the same cycle as o_frame_done. o_count excludes the partial word.
- Width rule: width is the number of cycles s2 was high, measured from rise to fall.

## Timing
- Reset values:
  - o_pixel = 0, o_index = 0, o_count = 0.
  - o_valid = 0, o_frame_done = 0, o_err = 0.
  - FSM in SYNC, all counters 0.
- Reset mid-frame discards everything. No strobes are issued in the reset cycle or the cycle after it.
- o_valid rises exactly 3 i_clk rising edges after the pin's falling edge that ends the 24th bit. The synchronizer adds 2 edges and the registered output adds 1.
- o_frame_done rises in the cycle the low count reaches RESET_CYC, i.e. RESET_CYC+3 edges after the last pin fall.
- Consecutive o_valid strobes are at least 24·(MIN_HIGH+1) cycles apart. No backpressure: the consumer must accept every strobe.
- o_valid and o_frame_done never coincide.
- Rise on the same cycle the low count reaches RESET_CYC: the latch wins, then the FSM enters HIGH on the next cycle only if the line is still high.

## Test plan
- Reset, line low 2400 cycles, then 24 bits encoding 0xA5F00F (1: 38 high / 22 low; 0: 19 / 41) -> o_valid once, o_pixel = 0xA5F00F, o_index = 0, latency 3 cycles after the last fall.
- 3 words 0x000001, 0xFFFFFF, 0x123456, then low 2400 cycles -> indices 0, 1, 2 with matching data; o_frame_done with o_count = 3; next frame restarts at index 0.
- Threshold boundary: high widths of 28 and 29 cycles -> decoded 0 and 1 respectively; width 7 -> o_err, bit dropped, word completes one bit later.
- Line held high 91 cycles mid-word -> o_err, no o_valid. The receiver waits for 2400 low cycles, then decodes the next word correctly.
- Frame of 1 word plus 10 bits, then latch -> o_valid once; o_frame_done with o_count = 1 and o_err in the same cycle.
- Assert i_rst after 12 bits, release, send a full gap plus 1 word -> no stale bits; o_pixel equals the new word, o_index = 0.
